fetch_stage: RTL

//  Parametrised instruction-fetch stage for the MIPS core. Owns the PC register, next-PC selection
//  (sequential, BEQ/BNE, J) and the IF/ID pipeline register with valid, stall and flush.

---
 rtl/fetch_stage_pkg.sv | 34 +++
 rtl/fetch_stage_next_pc_sel.sv | 72 +++++++
 rtl/fetch_stage.sv | 115 +++++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage_pkg
//  Description : Shared definitions for the MIPS instruction-fetch stage:
//                opcode constants, default widths, the NOP encoding, the
//                next-PC source enumeration and an immediate sign-extender.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    // Primary opcodes (instr[31:26]) of the control-flow instructions that
    // the execute stage resolves and feeds back into fetch.
    localparam logic [5:0]  c_OP_BEQ        = 6'h04;
    localparam logic [5:0]  c_OP_BNE        = 6'h05;
    localparam logic [5:0]  c_OP_J          = 6'h02;

    localparam int          c_INSTR_W_DFLT  = 32;
    localparam logic [31:0] c_NOP           = 32'h0000_0000;

    // Source selected for the next PC value.
    typedef enum logic [1:0] {
        SEL_SEQ  = 2'd0,
        SEL_HOLD = 2'd1,
        SEL_BR   = 2'd2,
        SEL_JUMP = 2'd3
    } pc_sel_e;

    // 16-bit branch immediate sign-extended to 32 bits.
    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_stage_next_pc_sel.sv
`default_nettype none
// ============================================================================
//  Module      : next_pc_sel
//  Description : Combinational next-PC computation for the fetch stage.
//                Resolves taken branches / jumps from EX and applies the
//                priority redirect > stall > sequential advance.
//  Ports       : pc            current PC
//                stall         hold request from decode
//                ex_*          branch/jump resolution of the EX instruction
//                pc_plus       pc + PC_INC (wraps modulo 2^ADDR_W)
//                next_pc       value the PC register loads on the next edge
//                redirect      taken branch or jump this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module next_pc_sel
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int PC_INC = 1
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              stall,
    input  logic              ex_branch_eq,
    input  logic              ex_branch_ne,
    input  logic              ex_zero,
    input  logic [ADDR_W-1:0] ex_pc_plus,
    input  logic [15:0]       ex_imm,
    input  logic              ex_jump,
    input  logic [25:0]       ex_jump_target,
    output logic [ADDR_W-1:0] pc_plus,
    output logic [ADDR_W-1:0] next_pc,
    output logic              redirect
);

    logic          w_taken_br;
    logic [31:0]   w_br_sum;
    pc_sel_e       w_sel;
    logic          w_unused_bits;

    // Addition done at 32 bits, then truncated: gives the modulo-2^ADDR_W
    // wrap for both forward and backward (negative immediate) branches.
    assign w_br_sum      = {{(32-ADDR_W){1'b0}}, ex_pc_plus} + sext16(ex_imm);
    assign w_unused_bits = ^{ex_jump_target, w_br_sum};

    assign pc_plus    = pc + ADDR_W'(PC_INC);
    // BNE is taken when the ALU result is non-zero.
    assign w_taken_br = (ex_branch_eq & ex_zero) | (ex_branch_ne & ~ex_zero);
    assign redirect   = w_taken_br | ex_jump;

    always_comb begin
        w_sel = SEL_SEQ;
        if (ex_jump) begin
            w_sel = SEL_JUMP;       // jump wins over a simultaneous branch
        end else if (w_taken_br) begin
            w_sel = SEL_BR;
        end else if (stall) begin
            w_sel = SEL_HOLD;
        end
    end

    always_comb begin
        next_pc = pc_plus;
        case (w_sel)
            SEL_JUMP: next_pc = ex_jump_target[ADDR_W-1:0];
            SEL_BR:   next_pc = w_br_sum[ADDR_W-1:0];
            SEL_HOLD: next_pc = pc;
            default:  next_pc = pc_plus;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : MIPS instruction-fetch stage. Owns the PC register, the
//                IF/ID pipeline register (valid / stall / flush) and a
//                saturating counter of control-flow redirects.
//  Ports       : clk, rst             clock, synchronous active-high reset
//                stall                hold PC and IF/ID
//                imem_addr/imem_rdata combinational instruction memory port
//                ex_*                 branch/jump resolution from EX
//                ifid_*               registered instruction to decode
//                redirect             combinational taken branch / jump
//                redirect_cnt         saturating redirect count
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int INSTR_W  = c_INSTR_W_DFLT,
    parameter int PC_INC   = 1,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               ex_branch_eq,
    input  logic               ex_branch_ne,
    input  logic               ex_zero,
    input  logic [ADDR_W-1:0]  ex_pc_plus,
    input  logic [15:0]        ex_imm,
    input  logic               ex_jump,
    input  logic [25:0]        ex_jump_target,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc_plus,
    output logic               ifid_valid,
    output logic               redirect,
    output logic [CNT_W-1:0]   redirect_cnt
);

    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_ifid_instr;
    logic [ADDR_W-1:0]  r_ifid_pc_plus;
    logic               r_ifid_valid;
    logic [CNT_W-1:0]   r_redirect_cnt;

    logic [ADDR_W-1:0]  w_next_pc;
    logic [ADDR_W-1:0]  w_pc_plus;
    logic               w_redirect;

    next_pc_sel #(
        .ADDR_W (ADDR_W),
        .PC_INC (PC_INC)
    ) u_next_pc_sel (
        .pc             (r_pc),
        .stall          (stall),
        .ex_branch_eq   (ex_branch_eq),
        .ex_branch_ne   (ex_branch_ne),
        .ex_zero        (ex_zero),
        .ex_pc_plus     (ex_pc_plus),
        .ex_imm         (ex_imm),
        .ex_jump        (ex_jump),
        .ex_jump_target (ex_jump_target),
        .pc_plus        (w_pc_plus),
        .next_pc        (w_next_pc),
        .redirect       (w_redirect)
    );

    // PC: the selector already folds redirect > stall > advance into next_pc.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= ADDR_W'(RESET_PC);
        end else begin
            r_pc <= w_next_pc;
        end
    end

    // IF/ID register. A redirect flushes the younger instruction even while
    // stalled; ifid_pc_plus is left as-is since a bubble carries no PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ifid_instr   <= INSTR_W'(c_NOP);
            r_ifid_pc_plus <= '0;
            r_ifid_valid   <= 1'b0;
        end else if (w_redirect) begin
            r_ifid_instr   <= INSTR_W'(c_NOP);
            r_ifid_valid   <= 1'b0;
        end else if (!stall) begin
            r_ifid_instr   <= imem_rdata;
            r_ifid_pc_plus <= w_pc_plus;
            r_ifid_valid   <= 1'b1;
        end
    end

    // Saturating redirect counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_cnt <= '0;
        end else if (w_redirect && (r_redirect_cnt != {CNT_W{1'b1}})) begin
            r_redirect_cnt <= r_redirect_cnt + 1'b1;
        end
    end

    assign imem_addr    = r_pc;
    assign redirect     = w_redirect;
    assign ifid_instr   = r_ifid_instr;
    assign ifid_pc_plus = r_ifid_pc_plus;
    assign ifid_valid   = r_ifid_valid;
    assign redirect_cnt = r_redirect_cnt;

endmodule
`default_nettype wire
